fc_l2_port_arbiter: RTL and testbench
=====================================

FC_L2_PORT_ARBITER -- requirements
Module: fc_l2_port_arbiter

Interface
REQ-001 The block SHALL have parameter NB_PORTS, default 4: number of requester ports; legal range 2..8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32: data width; BE width = DATA_WIDTH/8.
REQ-004 The block SHALL have parameter MAX_OUTST, default 4: outstanding-transaction capacity; power of two, 2..16.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port s_req_i, input, NB_PORTS bits: per-requester request.
REQ-008 The block SHALL have port s_add_i, input, NB_PORTS*ADDR_WIDTH bits: per-requester address.
REQ-009 The block SHALL have port s_wen_i, input, NB_PORTS bits: per-requester write enable, active-low (1 = read).
REQ-010 The block SHALL have port s_wdata_i, input, NB_PORTS*DATA_WIDTH bits: per-requester write data.
REQ-011 The block SHALL have port s_be_i, input, NB_PORTS*DATA_WIDTH/8 bits: per-requester byte enables.
REQ-012 The block SHALL have port s_gnt_o, output, NB_PORTS bits: per-requester grant.
REQ-013 The block SHALL have port s_r_valid_o, output, NB_PORTS bits: per-requester response valid.
REQ-014 The block SHALL have port s_r_rdata_o, output, DATA_WIDTH bits: read data, broadcast to all requesters.
REQ-015 The block SHALL have port s_r_opc_o, output, 1 bit: response error, broadcast to all requesters.
REQ-016 The block SHALL have ports m_req_o, m_add_o, m_wen_o, m_wdata_o and m_be_o, all outputs: the shared L2 master request, with widths 1, ADDR_WIDTH, 1, DATA_WIDTH and DATA_WIDTH/8.
REQ-017 The block SHALL have ports m_gnt_i, m_r_valid_i, m_r_rdata_i and m_r_opc_i, all inputs: the shared L2 master response side, with widths 1, 1, DATA_WIDTH and 1.
REQ-018 The block SHALL have port busy_o, output, 1 bit: asserted while at least one transaction is outstanding.
REQ-019 The block SHALL have port err_o, output, 1 bit: one-cycle pulse when a response arrives with no transaction outstanding.

Function
REQ-020 Requesters SHALL hold s_req_i and their payload stable until granted.
REQ-021 The L2 slave SHALL return exactly one m_r_valid_i per granted request, in grant order, no earlier than one cycle after the grant.
REQ-022 Arbitration SHALL be round-robin from a priority pointer prio: the winner is the first asserted s_req_i at or after index prio, searching upward with wrap from NB_PORTS-1 to 0.
REQ-023 m_req_o SHALL equal (any s_req_i) AND (outstanding count < MAX_OUTST), combinationally.
REQ-024 m_add_o, m_wen_o, m_wdata_o and m_be_o SHALL carry the winner's payload, combinationally.
REQ-025 s_gnt_o[winner] SHALL equal m_req_o AND m_gnt_i; all other s_gnt_o bits SHALL be 0; grant latency is 0 cycles.
REQ-026 On a grant (m_req_o AND m_gnt_i), prio SHALL become (winner+1) mod NB_PORTS, and the winner index SHALL be pushed into an ID FIFO of depth MAX_OUTST.
REQ-027 Without a grant, prio SHALL hold.
REQ-028 On m_r_valid_i with the FIFO non-empty:
  - the head index SHALL be popped;
  - s_r_valid_o[head] SHALL be 1 in that same cycle;
  - s_r_rdata_o and s_r_opc_o SHALL pass m_r_rdata_i and m_r_opc_i through combinationally.
REQ-029 On m_r_valid_i with the FIFO empty, all s_r_valid_o bits SHALL stay 0 and err_o SHALL be asserted for that cycle; no state SHALL change.
REQ-030 Push and pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-031 The count SHALL be clog2(MAX_OUTST)+1 bits wide; read and write pointers SHALL wrap modulo MAX_OUTST.
REQ-032 When the FIFO is full, m_req_o SHALL be 0, even if a pop occurs that same cycle.
REQ-033 busy_o SHALL equal (count != 0), taken from the register.
REQ-034 A requester withdrawing s_req_i before grant is a protocol violation; its behaviour is unspecified and it is flagged by an assertion.

Reset
REQ-035 When rst_i is asserted, prio, count, FIFO pointers and FIFO contents SHALL be cleared to 0 asynchronously.
REQ-036 While rst_i is asserted, m_req_o, all s_gnt_o bits, all s_r_valid_o bits, busy_o and err_o SHALL be 0.
REQ-037 Reset asserted with transactions in flight SHALL discard them; any later m_r_valid_i SHALL raise err_o.

Verification
REQ-038 All 4 requesters continuously requesting, m_gnt_i=1, one-cycle responses -> grants in order 0,1,2,3,0,...; each s_r_valid_o bit fires exactly one cycle after its grant.
REQ-039 MAX_OUTST=4, m_gnt_i=1, m_r_valid_i held 0 -> exactly 4 grants, then m_req_o=0 and busy_o=1; one response -> m_req_o=1 again in the following cycle.
REQ-040 Port 2 only, m_gnt_i=0 for 3 cycles then 1 -> s_gnt_o=4'b0100 in the 4th cycle; prio becomes 3.
REQ-041 Count=2, grant and response in the same cycle -> count stays 2; responses are routed to ports in grant order; m_r_opc_i=1 is seen on s_r_opc_o.
REQ-042 m_r_valid_i=1 with count=0 -> err_o=1 for one cycle; s_r_valid_o=0.
REQ-043 rst_i pulsed with count=3 -> count=0, busy_o=0 and prio=0 immediately; the next m_r_valid_i raises err_o.

Source files
------------

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter funnelling NB_PORTS requesters onto one L2 master port.
// An ID FIFO of granted port indices routes the in-order responses back to their requesters.
module fc_l2_port_arbiter #(
    parameter int NB_PORTS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_PORTS-1:0]              s_req_i,
    input  logic [NB_PORTS*ADDR_WIDTH-1:0]   s_add_i,
    input  logic [NB_PORTS-1:0]              s_wen_i,
    input  logic [NB_PORTS*DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [NB_PORTS*DATA_WIDTH/8-1:0] s_be_i,
    output logic [NB_PORTS-1:0]              s_gnt_o,
    output logic [NB_PORTS-1:0]              s_r_valid_o,
    output logic [DATA_WIDTH-1:0]            s_r_rdata_o,
    output logic                             s_r_opc_o,
    output logic                             m_req_o,
    output logic [ADDR_WIDTH-1:0]            m_add_o,
    output logic                             m_wen_o,
    output logic [DATA_WIDTH-1:0]            m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          m_be_o,
    input  logic                             m_gnt_i,
    input  logic                             m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            m_r_rdata_i,
    input  logic                             m_r_opc_i,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PW       = $clog2(NB_PORTS);
    localparam int FW       = $clog2(MAX_OUTST);
    localparam int CW       = FW + 1;

    logic [PW-1:0] prio;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic [PW-1:0] next_prio;
    logic          any_req;
    logic          not_full;
    logic          grant;
    logic          pop;

    logic [PW-1:0] id_fifo [MAX_OUTST];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] head;

    // Search upward from prio with wrap; the first requester found wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 0; i < NB_PORTS; i++) begin
            idx = PW'((int'(prio) + i) % NB_PORTS);
            if (!any_req && s_req_i[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        m_add_o   = '0;
        m_wen_o   = 1'b1;
        m_wdata_o = '0;
        m_be_o    = '0;
        for (int i = 0; i < NB_PORTS; i++) begin
            if (PW'(i) == winner) begin
                m_add_o   = s_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_wen_o   = s_wen_i[i];
                m_wdata_o = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                m_be_o    = s_be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // A full FIFO blocks new requests even when a response frees a slot this cycle.
    assign not_full  = (count < CW'(MAX_OUTST));
    assign m_req_o   = any_req && not_full && !rst_i;
    assign grant     = m_req_o && m_gnt_i;
    assign head      = id_fifo[rd_ptr];
    assign pop       = m_r_valid_i && (count != '0) && !rst_i;
    assign err_o     = m_r_valid_i && (count == '0) && !rst_i;
    assign busy_o    = (count != '0);
    assign next_prio = (winner == PW'(NB_PORTS - 1)) ? '0 : winner + PW'(1);

    assign s_r_rdata_o = m_r_rdata_i;
    assign s_r_opc_o   = m_r_opc_i;

    always_comb begin
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        if (grant) begin
            s_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            s_r_valid_o[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                id_fifo[i] <= '0;
            end
        end else begin
            if (grant) begin
                prio            <= next_prio;
                id_fifo[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
            end
            case ({grant, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A requester must keep its request up until it has been granted.
    for (genvar g = 0; g < NB_PORTS; g++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (s_req_i[g] && !s_gnt_o[g]) |=> s_req_i[g]);
    end
`endif

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Randomized and directed bench for fc_l2_port_arbiter, checked against a
// queue-based reference model of the grant order and response routing.
module tb_fc_l2_port_arbiter;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NB-1:0]    s_req_i;
    logic [NB*AW-1:0] s_add_i;
    logic [NB-1:0]    s_wen_i;
    logic [NB*DW-1:0] s_wdata_i;
    logic [NB*BW-1:0] s_be_i;
    logic [NB-1:0]    s_gnt_o;
    logic [NB-1:0]    s_r_valid_o;
    logic [DW-1:0]    s_r_rdata_o;
    logic             s_r_opc_o;
    logic             m_req_o;
    logic [AW-1:0]    m_add_o;
    logic             m_wen_o;
    logic [DW-1:0]    m_wdata_o;
    logic [BW-1:0]    m_be_o;
    logic             m_gnt_i;
    logic             m_r_valid_i;
    logic [DW-1:0]    m_r_rdata_i;
    logic             m_r_opc_i;
    logic             busy_o;
    logic             err_o;

    fc_l2_port_arbiter #(
        .NB_PORTS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
        .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
        .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
        .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i),
        .m_r_rdata_i(m_r_rdata_i), .m_r_opc_i(m_r_opc_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: rotating priority plus an in-order queue of granted ports.
    int            prio_m = 0;
    int            q[$];
    logic [NB-1:0] pending = '0;
    logic [AW-1:0] addr_a  [NB];
    logic [DW-1:0] wdata_a [NB];
    logic [BW-1:0] be_a    [NB];
    logic          wen_a   [NB];

    int            exp_win;
    logic          exp_mreq;
    logic          exp_err;
    logic          exp_busy;
    logic [NB-1:0] exp_gnt;
    logic [NB-1:0] exp_rv;

    task automatic new_payload(input int p);
        addr_a[p]  = $urandom;
        wdata_a[p] = $urandom;
        be_a[p]    = BW'($urandom);
        wen_a[p]   = 1'($urandom);
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic opc);
        @(negedge clk_i);
        s_req_i     = pending;
        m_gnt_i     = gnt;
        m_r_valid_i = rv;
        m_r_opc_i   = opc;
        m_r_rdata_i = $urandom;
        for (int p = 0; p < NB; p++) begin
            s_add_i[p*AW +: AW]   = addr_a[p];
            s_wdata_i[p*DW +: DW] = wdata_a[p];
            s_be_i[p*BW +: BW]    = be_a[p];
            s_wen_i[p]            = wen_a[p];
        end
        #1;
        exp_win = -1;
        for (int k = 0; k < NB; k++) begin
            if (exp_win < 0 && pending[(prio_m + k) % NB]) exp_win = (prio_m + k) % NB;
        end
        exp_busy = (q.size() != 0);
        exp_mreq = (exp_win >= 0) && (q.size() < MO);
        exp_gnt  = (exp_mreq && gnt) ? (NB'(1) << exp_win) : '0;
        exp_rv   = (rv && q.size() > 0) ? (NB'(1) << q[0]) : '0;
        exp_err  = rv && (q.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (exp_rv != '0) q.delete(0);
        if (exp_gnt != '0) begin
            q.push_back(exp_win);
            prio_m = (exp_win + 1) % NB;
            pending[exp_win] = 1'b0;
            new_payload(exp_win);
        end
    endtask

    task automatic settle();
        int n = 0;
        while ((pending != '0 || q.size() != 0) && n < 50) begin
            drive(1'b1, q.size() > 0, 1'b0);
            tick();
            n++;
        end
        vectors++;
        if (pending != '0 || q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL settle_timeout: pending %b outstanding %0d, required 0/0", pending, q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        s_req_i = '1; m_gnt_i = 1'b1; m_r_valid_i = 1'b1;
        #1;
        vectors += 5;
        if (m_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_req: got %b required 0", m_req_o); end
        if (s_gnt_o !== '0) begin miscompares++; $display("[TB] FAIL rst_gnt: got %b required 0", s_gnt_o); end
        if (s_r_valid_o !== '0) begin miscompares++; $display("[TB] FAIL rst_rvalid: got %b required 0", s_r_valid_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b required 0", busy_o); end
        if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err: got %b required 0", err_o); end
        @(negedge clk_i);
        s_req_i = '0; m_gnt_i = 1'b0; m_r_valid_i = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 12; i++) begin
            pending = '1;
            drive(1'b1, q.size() > 0, 1'b0);
            vectors += 2;
            if (s_gnt_o !== (4'b0001 << (i % 4))) begin
                miscompares++; $display("[TB] FAIL rr_gnt[%0d]: got %b required %b", i, s_gnt_o, 4'b0001 << (i % 4));
            end
            if (m_add_o !== addr_a[i % 4]) begin
                miscompares++; $display("[TB] FAIL rr_addr[%0d]: got %h required %h", i, m_add_o, addr_a[i % 4]);
            end
            if (i > 0) begin
                vectors++;
                if (s_r_valid_o !== (4'b0001 << ((i - 1) % 4))) begin
                    miscompares++; $display("[TB] FAIL rr_rvalid[%0d]: got %b required %b", i, s_r_valid_o, 4'b0001 << ((i - 1) % 4));
                end
            end
            tick();
        end
        settle();
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) begin
            pending = '1;
            drive(1'b1, 1'b0, 1'b0);
            vectors += 3;
            if (m_req_o !== (k < 4)) begin miscompares++; $display("[TB] FAIL full_mreq[%0d]: got %b required %b", k, m_req_o, k < 4); end
            if (busy_o !== (k > 0)) begin miscompares++; $display("[TB] FAIL full_busy[%0d]: got %b required %b", k, busy_o, k > 0); end
            if (s_gnt_o !== exp_gnt) begin miscompares++; $display("[TB] FAIL full_gnt[%0d]: got %b required %b", k, s_gnt_o, exp_gnt); end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        vectors += 3;
        if (m_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pop_mreq: got %b required 0", m_req_o); end
        if (s_gnt_o !== '0) begin miscompares++; $display("[TB] FAIL full_pop_gnt: got %b required 0", s_gnt_o); end
        if (s_r_valid_o !== exp_rv) begin miscompares++; $display("[TB] FAIL full_pop_rvalid: got %b required %b", s_r_valid_o, exp_rv); end
        tick();
        drive(1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (m_req_o !== 1'b1) begin miscompares++; $display("[TB] FAIL full_reopen_mreq: got %b required 1", m_req_o); end
        if (s_gnt_o !== exp_gnt) begin miscompares++; $display("[TB] FAIL full_reopen_gnt: got %b required %b", s_gnt_o, exp_gnt); end
        tick();
        settle();
    endtask

    task automatic test_gnt_stall();
        pending = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            vectors += 3;
            if (s_gnt_o !== '0) begin miscompares++; $display("[TB] FAIL stall_gnt[%0d]: got %b required 0", k, s_gnt_o); end
            if (m_req_o !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_mreq[%0d]: got %b required 1", k, m_req_o); end
            if (m_add_o !== addr_a[2]) begin miscompares++; $display("[TB] FAIL stall_addr[%0d]: got %h required %h", k, m_add_o, addr_a[2]); end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if (s_gnt_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL stall_release: got %b required 0100", s_gnt_o); end
        tick();
        pending = 4'b1001;
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if (s_gnt_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL stall_prio3: got %b required 1000", s_gnt_o); end
        tick();
        drive(1'b1, 1'b1, 1'b0);
        vectors += 2;
        if (s_gnt_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL stall_wrap: got %b required 0001", s_gnt_o); end
        if (s_r_valid_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL stall_rsp0: got %b required 0100", s_r_valid_o); end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if (s_r_valid_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL stall_rsp1: got %b required 1000", s_r_valid_o); end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if (s_r_valid_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL stall_rsp2: got %b required 0001", s_r_valid_o); end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_idle_busy: got %b required 0", busy_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        pending = 4'b0010; drive(1'b1, 1'b0, 1'b0); tick();
        pending = 4'b0100; drive(1'b1, 1'b0, 1'b0); tick();
        pending = 4'b1000;
        drive(1'b1, 1'b1, 1'b1);
        vectors += 4;
        if (s_r_valid_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL same_rvalid: got %b required 0010", s_r_valid_o); end
        if (s_r_opc_o !== 1'b1) begin miscompares++; $display("[TB] FAIL same_opc: got %b required 1", s_r_opc_o); end
        if (s_r_rdata_o !== m_r_rdata_i) begin miscompares++; $display("[TB] FAIL same_rdata: got %h required %h", s_r_rdata_o, m_r_rdata_i); end
        if (s_gnt_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL same_gnt: got %b required 1000", s_gnt_o); end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors += 2;
        if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL same_busy: got %b required 1", busy_o); end
        if (s_r_valid_o !== 4'b0100) begin miscompares++; $display("[TB] FAIL same_rsp1: got %b required 0100", s_r_valid_o); end
        tick();
        drive(1'b0, 1'b1, 1'b0);
        vectors += 2;
        if (s_r_valid_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL same_rsp2: got %b required 1000", s_r_valid_o); end
        if (s_r_opc_o !== 1'b0) begin miscompares++; $display("[TB] FAIL same_opc0: got %b required 0", s_r_opc_o); end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL same_drained: got %b required 0", busy_o); end
        tick();
    endtask

    task automatic test_err();
        drive(1'b0, 1'b1, 1'b0);
        vectors += 2;
        if (err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL err_pulse: got %b required 1", err_o); end
        if (s_r_valid_o !== '0) begin miscompares++; $display("[TB] FAIL err_rvalid: got %b required 0", s_r_valid_o); end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        vectors += 2;
        if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear: got %b required 0", err_o); end
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL err_busy: got %b required 0", busy_o); end
        tick();
    endtask

    task automatic test_reset_inflight();
        for (int p = 0; p < 3; p++) begin
            pending = NB'(1) << p;
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL inflight_busy: got %b required 1", busy_o); end
        tick();
        @(negedge clk_i);
        rst_i = 1'b1;
        m_r_valid_i = 1'b1;
        #1;
        q.delete();
        prio_m = 0;
        vectors += 3;
        if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL inflight_rst_busy: got %b required 0", busy_o); end
        if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL inflight_rst_err: got %b required 0", err_o); end
        if (s_r_valid_o !== '0) begin miscompares++; $display("[TB] FAIL inflight_rst_rvalid: got %b required 0", s_r_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        m_r_valid_i = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if (err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL inflight_err: got %b required 1", err_o); end
        tick();
        pending = 4'b1010;
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if (s_gnt_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL inflight_prio0: got %b required 0010", s_gnt_o); end
        tick();
        settle();
    endtask

    task automatic test_random();
        logic gnt;
        logic rv;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NB; p++) begin
                if (!pending[p] && $urandom_range(0, 2) == 0) begin
                    pending[p] = 1'b1;
                    new_payload(p);
                end
            end
            gnt = ($urandom_range(0, 3) != 0);
            rv  = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            drive(gnt, rv, 1'($urandom));
            vectors += 6;
            if (m_req_o !== exp_mreq) begin miscompares++; $display("[TB] FAIL rnd_mreq[%0d]: got %b required %b", c, m_req_o, exp_mreq); end
            if (s_gnt_o !== exp_gnt) begin miscompares++; $display("[TB] FAIL rnd_gnt[%0d]: got %b required %b", c, s_gnt_o, exp_gnt); end
            if (s_r_valid_o !== exp_rv) begin miscompares++; $display("[TB] FAIL rnd_rvalid[%0d]: got %b required %b", c, s_r_valid_o, exp_rv); end
            if (err_o !== exp_err) begin miscompares++; $display("[TB] FAIL rnd_err[%0d]: got %b required %b", c, err_o, exp_err); end
            if (busy_o !== exp_busy) begin miscompares++; $display("[TB] FAIL rnd_busy[%0d]: got %b required %b", c, busy_o, exp_busy); end
            if (s_r_opc_o !== m_r_opc_i) begin miscompares++; $display("[TB] FAIL rnd_opc[%0d]: got %b required %b", c, s_r_opc_o, m_r_opc_i); end
            if (exp_win >= 0) begin
                vectors += 4;
                if (m_add_o !== addr_a[exp_win]) begin miscompares++; $display("[TB] FAIL rnd_addr[%0d]: got %h required %h", c, m_add_o, addr_a[exp_win]); end
                if (m_wdata_o !== wdata_a[exp_win]) begin miscompares++; $display("[TB] FAIL rnd_wdata[%0d]: got %h required %h", c, m_wdata_o, wdata_a[exp_win]); end
                if (m_be_o !== be_a[exp_win]) begin miscompares++; $display("[TB] FAIL rnd_be[%0d]: got %h required %h", c, m_be_o, be_a[exp_win]); end
                if (m_wen_o !== wen_a[exp_win]) begin miscompares++; $display("[TB] FAIL rnd_wen[%0d]: got %b required %b", c, m_wen_o, wen_a[exp_win]); end
            end
            tick();
        end
        settle();
    endtask

    initial begin
        rst_i = 1'b1;
        s_req_i = '0; s_add_i = '0; s_wen_i = '0; s_wdata_i = '0; s_be_i = '0;
        m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_opc_i = 1'b0;
        for (int p = 0; p < NB; p++) new_payload(p);
        repeat (2) @(posedge clk_i);
        test_reset();
        test_round_robin();
        test_full();
        test_gnt_stall();
        test_same_cycle();
        test_err();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
